// File: rtl/digital_tube_pkg.sv
// Shared constants, state type and glyph table for the multiplexed 7-segment tube driver.
// Segment vectors are active low with bit 0 = segment a and bit 6 = segment g.
package digital_tube_pkg;

  localparam int NUM_DIGITS    = 6;
  localparam int BRIGHT_LEVELS = 16;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_0   = 7'h40;
  localparam logic [6:0] GLYPH_1   = 7'h79;
  localparam logic [6:0] GLYPH_2   = 7'h24;
  localparam logic [6:0] GLYPH_3   = 7'h30;
  localparam logic [6:0] GLYPH_4   = 7'h19;
  localparam logic [6:0] GLYPH_5   = 7'h12;
  localparam logic [6:0] GLYPH_6   = 7'h02;
  localparam logic [6:0] GLYPH_7   = 7'h78;
  localparam logic [6:0] GLYPH_8   = 7'h00;
  localparam logic [6:0] GLYPH_9   = 7'h10;
  localparam logic [6:0] GLYPH_A   = 7'h08;
  localparam logic [6:0] GLYPH_B   = 7'h03;
  localparam logic [6:0] GLYPH_C   = 7'h46;
  localparam logic [6:0] GLYPH_D   = 7'h21;
  localparam logic [6:0] GLYPH_E   = 7'h06;
  localparam logic [6:0] GLYPH_F   = 7'h0E;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } scan_state_t;

  function automatic logic [6:0] glyphLookup(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'h0:    seg = GLYPH_0;
      4'h1:    seg = GLYPH_1;
      4'h2:    seg = GLYPH_2;
      4'h3:    seg = GLYPH_3;
      4'h4:    seg = GLYPH_4;
      4'h5:    seg = GLYPH_5;
      4'h6:    seg = GLYPH_6;
      4'h7:    seg = GLYPH_7;
      4'h8:    seg = GLYPH_8;
      4'h9:    seg = GLYPH_9;
      4'hA:    seg = GLYPH_A;
      4'hB:    seg = GLYPH_B;
      4'hC:    seg = GLYPH_C;
      4'hD:    seg = GLYPH_D;
      4'hE:    seg = GLYPH_E;
      default: seg = GLYPH_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/digital_tube_glyph.sv
// Combinational hex-code to active-low 7-segment decoder with a blank override.
// Shared between the scanned controller and the static per-digit driver.
module digital_tube_glyph
  import digital_tube_pkg::*;
(
  input  logic [3:0] i_code,
  input  logic       i_blank,
  output logic [6:0] o_seg_n
);

  assign o_seg_n = i_blank ? SEG_BLANK : glyphLookup(i_code);

endmodule

// File: rtl/digital_tube_scan_ctrl.sv
// Six-digit time-multiplexed tube scanner: frame-synchronous double buffer,
// leading-zero blanking, anti-ghosting guard time and 16-level PWM brightness.
module digital_tube_scan_ctrl
  import digital_tube_pkg::*;
#(
  parameter int DIGIT_CYCLES = 25000,
  parameter int GUARD        = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_enable,
  input  logic        i_load,
  input  logic [23:0] i_digits,
  input  logic        i_blank_lz,
  input  logic [3:0]  i_brightness,
  output logic [6:0]  o_seg_n,
  output logic [5:0]  o_dig_n,
  output logic        o_frame_done
);

  localparam int TICK_W = $clog2(DIGIT_CYCLES);
  localparam int SLICE  = DIGIT_CYCLES / BRIGHT_LEVELS;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_CYCLES - 1);
  localparam logic [2:0]        IDX_LAST  = 3'(NUM_DIGITS - 1);

  scan_state_t r_state;
  scan_state_t w_next_state;
  logic        w_scan;

  logic [TICK_W-1:0]     r_tick;
  logic [2:0]            r_idx;
  logic [3:0]            r_bri;
  logic [23:0]           r_pend_digits;
  logic [23:0]           r_act_digits;
  logic                  r_pend_lz;
  logic                  r_act_lz;
  logic                  r_pend_valid;

  logic                  w_slot_end;
  logic                  w_boundary;
  logic [3:0]            w_bri;
  logic [31:0]           w_on_len;
  logic                  w_lit;
  logic                  w_lz_run;
  logic [NUM_DIGITS-1:0] w_blank_mask;
  logic [3:0]            w_code;
  logic                  w_dark;
  logic [6:0]            w_glyph;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_scan       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_enable) begin
          w_next_state = ST_SCAN;
          w_scan       = 1'b1;
        end
      end
      ST_SCAN: begin
        if (i_enable) w_scan = 1'b1;
        else          w_next_state = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_slot_end = (r_tick == TICK_LAST);
  assign w_boundary = w_scan && w_slot_end && (r_idx == IDX_LAST);
  // Brightness is taken live on the first tick of a slot so tick 0 already uses it.
  assign w_bri      = (r_tick == '0) ? i_brightness : r_bri;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick <= '0;
      r_idx  <= '0;
      r_bri  <= '0;
    end else if (!w_scan) begin
      r_tick <= '0;
      r_idx  <= '0;
      r_bri  <= '0;
    end else begin
      r_bri <= w_bri;
      if (w_slot_end) begin
        r_tick <= '0;
        r_idx  <= (r_idx == IDX_LAST) ? 3'd0 : r_idx + 3'd1;
      end else begin
        r_tick <= r_tick + TICK_W'(1);
      end
    end
  end

  // A load landing on the boundary cycle bypasses pending and goes straight to active.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_digits <= '0;
      r_pend_lz     <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_act_digits  <= '0;
      r_act_lz      <= 1'b0;
    end else begin
      if (i_load) begin
        r_pend_digits <= i_digits;
        r_pend_lz     <= i_blank_lz;
        r_pend_valid  <= 1'b1;
      end
      if (w_boundary) begin
        r_pend_valid <= 1'b0;
        if (i_load) begin
          r_act_digits <= i_digits;
          r_act_lz     <= i_blank_lz;
        end else if (r_pend_valid) begin
          r_act_digits <= r_pend_digits;
          r_act_lz     <= r_pend_lz;
        end
      end
    end
  end

  always_comb begin
    w_blank_mask = '0;
    w_lz_run     = r_act_lz;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      w_lz_run        = w_lz_run && (r_act_digits[4*k +: 4] == 4'd0);
      w_blank_mask[k] = w_lz_run;
    end
  end

  always_comb begin
    w_code = 4'd0;
    case (r_idx)
      3'd0:    w_code = r_act_digits[3:0];
      3'd1:    w_code = r_act_digits[7:4];
      3'd2:    w_code = r_act_digits[11:8];
      3'd3:    w_code = r_act_digits[15:12];
      3'd4:    w_code = r_act_digits[19:16];
      3'd5:    w_code = r_act_digits[23:20];
      default: w_code = 4'd0;
    endcase
  end

  assign w_on_len = (32'(w_bri) + 32'd1) * 32'(SLICE);
  assign w_lit    = (32'(r_tick) >= 32'(GUARD)) && (32'(r_tick) < w_on_len);
  assign w_dark   = !w_scan || !w_lit || w_blank_mask[r_idx];

  digital_tube_glyph u_glyph (
    .i_code  (w_code),
    .i_blank (w_dark),
    .o_seg_n (w_glyph)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_seg_n      <= SEG_BLANK;
      o_dig_n      <= 6'h3F;
      o_frame_done <= 1'b0;
    end else begin
      o_seg_n      <= w_glyph;
      o_dig_n      <= w_dark ? 6'h3F : ~(6'd1 << r_idx);
      o_frame_done <= w_boundary;
    end
  end

endmodule

// File: tb/tb_digital_tube_scan_ctrl.sv
// Self-checking bench for digital_tube_scan_ctrl: table vectors, hand-written
// corner sequences and a randomized run, all checked against a behavioural model.
module tb_digital_tube_scan_ctrl;

  localparam int DC    = 32;
  localparam int GD    = 1;
  localparam int FRAME = 6 * DC;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b1;
  logic        enable     = 1'b0;
  logic        load       = 1'b0;
  logic        blankLz    = 1'b0;
  logic [23:0] digits     = '0;
  logic [3:0]  brightness = '0;
  logic [6:0]  segN;
  logic [5:0]  digN;
  logic        frameDone;

  int total = 0;
  int bad = 0;
  int modelFails = 0;
  int pos = 0;
  logic watchOnes = 1'b0;
  logic sawOne = 1'b0;

  typedef struct {
    logic [23:0] digits;
    logic        lz;
    logic [3:0]  bri;
    int          slot;
    int          tk;
    logic [5:0]  dig;
    logic [6:0]  seg;
  } vec_t;

  vec_t vecs [19];

  digital_tube_scan_ctrl #(.DIGIT_CYCLES(DC), .GUARD(GD)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_enable     (enable),
    .i_load       (load),
    .i_digits     (digits),
    .i_blank_lz   (blankLz),
    .i_brightness (brightness),
    .o_seg_n      (segN),
    .o_dig_n      (digN),
    .o_frame_done (frameDone)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] glyphOf(input logic [3:0] c);
    case (c)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  function automatic logic [5:0] digSel(input int k);
    return ~(6'd1 << k);
  endfunction

  // Reference model: scan position counted in cycles since scanning began.
  logic [6:0]  eSeg = 7'h7F;
  logic [5:0]  eDig = 6'h3F;
  logic        eFd = 1'b0;
  int          mPos = 0;
  logic [3:0]  mBri = '0;
  logic [23:0] mAct = '0;
  logic [23:0] mPend = '0;
  logic        mActLz = 1'b0;
  logic        mPendLz = 1'b0;
  logic        mPv = 1'b0;

  always @(posedge clk or negedge rst_n) begin : refModel
    int t;
    int k;
    logic lit;
    logic blk;
    logic bnd;
    if (!rst_n) begin
      mPos = 0; mBri = '0; mAct = '0; mPend = '0;
      mActLz = 1'b0; mPendLz = 1'b0; mPv = 1'b0;
      eSeg = 7'h7F; eDig = 6'h3F; eFd = 1'b0;
    end else begin
      bnd = 1'b0;
      if (enable) begin
        t = mPos % DC;
        k = (mPos / DC) % 6;
        if (t == 0) mBri = brightness;
        lit = (t >= GD) && (t < (int'(mBri) + 1) * (DC / 16));
        blk = mActLz && (k > 0) && ((mAct >> (4 * k)) == 24'd0);
        if (lit && !blk) begin
          eSeg = glyphOf(4'(mAct >> (4 * k)));
          eDig = digSel(k);
        end else begin
          eSeg = 7'h7F;
          eDig = 6'h3F;
        end
        bnd = (t == DC - 1) && (k == 5);
        eFd = bnd;
        mPos++;
      end else begin
        mPos = 0; mBri = '0;
        eSeg = 7'h7F; eDig = 6'h3F; eFd = 1'b0;
      end
      if (bnd) begin
        if (load) begin
          mAct = digits; mActLz = blankLz;
        end else if (mPv) begin
          mAct = mPend; mActLz = mPendLz;
        end
      end
      if (load) begin
        mPend = digits; mPendLz = blankLz; mPv = 1'b1;
      end
      if (bnd) mPv = 1'b0;
    end
  end

  always @(negedge clk) begin
    total++;
    if (segN !== eSeg || digN !== eDig || frameDone !== eFd) begin
      bad++;
      if (modelFails < 20)
        $display("[TB] FAIL model t=%0t seg=%h exp=%h dig=%h exp=%h fd=%b exp=%b",
                 $time, segN, eSeg, digN, eDig, frameDone, eFd);
      modelFails++;
    end
    if (watchOnes && digN != 6'h3F && segN == 7'h79) sawOne = 1'b1;
  end

  task automatic nextCycle();
    @(negedge clk);
    #1;
    pos++;
  endtask

  task automatic advanceTo(input int target);
    while (pos < target) nextCycle();
  endtask

  task automatic checkOutput(input string name, input logic [6:0] expSeg,
                             input logic [5:0] expDig, input logic expFd);
    total++;
    if (segN !== expSeg || digN !== expDig || frameDone !== expFd) begin
      bad++;
      $display("[TB] FAIL %s pos=%0d seg=%h exp=%h dig=%h exp=%h fd=%b exp=%b",
               name, pos, segN, expSeg, digN, expDig, frameDone, expFd);
    end
  endtask

  task automatic doReset();
    nextCycle();
    rst_n = 1'b0; enable = 1'b0; load = 1'b0;
    digits = '0; blankLz = 1'b0; brightness = '0;
    #1;
    checkOutput("resetValues", 7'h7F, 6'h3F, 1'b0);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
  endtask

  task automatic startScan(input logic [3:0] bri);
    brightness = bri;
    enable = 1'b1;
    pos = -1;
  endtask

  task automatic applyStimulus(input vec_t v, input int n);
    int p;
    doReset();
    digits = v.digits; blankLz = v.lz; load = 1'b1;
    nextCycle();
    load = 1'b0;
    startScan(v.bri);
    p = FRAME + DC * v.slot + v.tk;
    advanceTo(p);
    checkOutput($sformatf("vec%0d", n), v.seg, v.dig, (p % FRAME) == FRAME - 1);
  endtask

  initial begin
    vecs[0]  = '{24'h123456, 1'b0, 4'd15, 0, 5,  6'h3E, 7'h02};
    vecs[1]  = '{24'h123456, 1'b0, 4'd15, 5, 31, 6'h1F, 7'h79};
    vecs[2]  = '{24'h123456, 1'b0, 4'd15, 3, 0,  6'h3F, 7'h7F};
    vecs[3]  = '{24'h000070, 1'b1, 4'd15, 5, 10, 6'h3F, 7'h7F};
    vecs[4]  = '{24'h000070, 1'b1, 4'd15, 2, 10, 6'h3F, 7'h7F};
    vecs[5]  = '{24'h000070, 1'b1, 4'd15, 1, 10, 6'h3D, 7'h78};
    vecs[6]  = '{24'h000070, 1'b1, 4'd15, 0, 10, 6'h3E, 7'h40};
    vecs[7]  = '{24'h000070, 1'b0, 4'd15, 4, 10, 6'h2F, 7'h40};
    vecs[8]  = '{24'h123456, 1'b0, 4'd0,  2, 1,  6'h3B, 7'h19};
    vecs[9]  = '{24'h123456, 1'b0, 4'd0,  2, 2,  6'h3F, 7'h7F};
    vecs[10] = '{24'h123456, 1'b0, 4'd7,  1, 15, 6'h3D, 7'h12};
    vecs[11] = '{24'h123456, 1'b0, 4'd7,  1, 16, 6'h3F, 7'h7F};
    vecs[12] = '{24'hABCDEF, 1'b0, 4'd15, 0, 3,  6'h3E, 7'h0E};
    vecs[13] = '{24'hABCDEF, 1'b0, 4'd15, 5, 3,  6'h1F, 7'h08};
    vecs[14] = '{24'hABCDEF, 1'b0, 4'd15, 3, 3,  6'h37, 7'h46};
    vecs[15] = '{24'h890000, 1'b1, 4'd15, 5, 3,  6'h1F, 7'h00};
    vecs[16] = '{24'h890000, 1'b1, 4'd15, 2, 3,  6'h3B, 7'h40};
    vecs[17] = '{24'h000000, 1'b1, 4'd15, 0, 3,  6'h3E, 7'h40};
    vecs[18] = '{24'h000000, 1'b1, 4'd15, 1, 3,  6'h3F, 7'h7F};

    for (int i = 0; i < 19; i++) applyStimulus(vecs[i], i);

    // Last write wins before the boundary; a boundary-cycle load shows next frame.
    doReset();
    startScan(4'd15);
    watchOnes = 1'b1;
    sawOne = 1'b0;
    advanceTo(50);
    digits = 24'h111111; load = 1'b1;
    nextCycle();
    load = 1'b0;
    advanceTo(100);
    digits = 24'h222222; load = 1'b1;
    nextCycle();
    load = 1'b0;
    for (int k = 0; k < 6; k++) begin
      advanceTo(FRAME + DC * k + 5);
      checkOutput($sformatf("lastWins%0d", k), 7'h24, digSel(k), 1'b0);
    end
    advanceTo(2 * FRAME - 2);
    checkOutput("preBoundary", 7'h24, 6'h1F, 1'b0);
    digits = 24'h333333; load = 1'b1;
    nextCycle();
    load = 1'b0;
    checkOutput("boundaryPulse", 7'h24, 6'h1F, 1'b1);
    advanceTo(2 * FRAME + 5);
    checkOutput("boundaryLoad", 7'h30, 6'h3E, 1'b0);
    watchOnes = 1'b0;
    total++;
    if (sawOne !== 1'b0) begin
      bad++;
      $display("[TB] FAIL neverOnes saw=%b exp=0", sawOne);
    end

    // Enable drop mid-slot goes dark next edge; re-enable restarts at digit 0.
    doReset();
    digits = 24'h123456; load = 1'b1;
    nextCycle();
    load = 1'b0;
    startScan(4'd15);
    advanceTo(70);
    checkOutput("beforeDisable", 7'h40, 6'h3B, 1'b0);
    enable = 1'b0;
    nextCycle();
    checkOutput("disabledDark", 7'h7F, 6'h3F, 1'b0);
    nextCycle();
    nextCycle();
    startScan(4'd15);
    advanceTo(0);
    checkOutput("restartGuard", 7'h7F, 6'h3F, 1'b0);
    advanceTo(1);
    checkOutput("restartFirst", 7'h40, 6'h3E, 1'b0);
    advanceTo(DC - 1);
    checkOutput("restartSlotEnd", 7'h40, 6'h3E, 1'b0);
    advanceTo(DC + 1);
    checkOutput("restartDigit1", 7'h40, 6'h3D, 1'b0);

    // Mid-frame reset with pending data: pending is lost, first frame has no pulse.
    doReset();
    digits = 24'h987654; load = 1'b1;
    nextCycle();
    load = 1'b0;
    startScan(4'd15);
    advanceTo(100);
    checkOutput("preReset", 7'h40, 6'h37, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncReset", 7'h7F, 6'h3F, 1'b0);
    nextCycle();
    rst_n = 1'b1;
    pos = -1;
    begin
      int early = 0;
      while (pos < FRAME - 2) begin
        nextCycle();
        if (frameDone !== 1'b0) early++;
      end
      total++;
      if (early != 0) begin
        bad++;
        $display("[TB] FAIL earlyFrameDone count=%0d exp=0", early);
      end
    end
    advanceTo(FRAME - 1);
    checkOutput("firstPulse", 7'h40, 6'h1F, 1'b1);
    for (int k = 0; k < 6; k++) begin
      advanceTo(FRAME + DC * k + 3);
      checkOutput($sformatf("pendLost%0d", k), 7'h40, digSel(k), 1'b0);
    end

    // Randomized traffic checked cycle by cycle against the model.
    doReset();
    startScan(4'($urandom_range(0, 15)));
    for (int c = 0; c < 6000; c++) begin
      nextCycle();
      load = ($urandom_range(0, 99) == 0);
      if (load) begin
        for (int n = 0; n < 6; n++)
          digits[4*n +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
        blankLz = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 49) == 0) brightness = 4'($urandom_range(0, 15));
      if (enable && $urandom_range(0, 799) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
    end
    load = 1'b0;
    nextCycle();
    nextCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
